// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter.
//   shift_op_e     : 3-bit shift op code carried through the pipe
//   shamt_w()      : shift-amount width for a given operand width
//   lvl_per_stage(): number of mux levels each register stage applies
// Optional feature macro: SHIFT_ROTATE_EN (used by the importing modules).
package shift_pkg;

  typedef enum logic [2:0] {
    SHIFT_SLL = 3'b000,
    SHIFT_SRL = 3'b001,
    SHIFT_SRA = 3'b010,
    SHIFT_ROL = 3'b011,
    SHIFT_ROR = 3'b100
  } shift_op_e;

  function automatic int unsigned shamt_w(input int unsigned width);
    return $clog2(width);
  endfunction

  // ceil(levels / stages); trailing stages may end up pure pass-through.
  function automatic int unsigned lvl_per_stage(input int unsigned width,
                                                input int unsigned stages);
    if (stages == 0) begin
      return shamt_w(width);
    end
    return (shamt_w(width) + stages - 1) / stages;
  endfunction

endpackage

// File: rtl/shift_stage.sv
// Combinational slice of the barrel shifter: applies mux levels
// FIRST_LVL .. FIRST_LVL+NUM_LVL-1 to the operand. Level j shifts by 2^j
// when shamt[j] is set; levels at or beyond $clog2(WIDTH) pass through.
// Optional feature macro: SHIFT_ROTATE_EN (builds the rotate muxes).
// Ports:
//   operand : data entering this slice
//   shamt   : full original shift amount (only this slice's bits are used)
//   op      : shift op code
//   sign    : original operand MSB, used as SRA fill
//   result  : data leaving this slice
module shift_stage
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned FIRST_LVL = 0,
  parameter int unsigned NUM_LVL   = 1
) (
  input  logic [WIDTH-1:0]         operand,
  input  logic [$clog2(WIDTH)-1:0] shamt,
  input  shift_op_e                op,
  input  logic                     sign,
  output logic [WIDTH-1:0]         result
);

  localparam int unsigned SW = shamt_w(WIDTH);

  logic [WIDTH-1:0] d;

  // Shift distances are constants once the loop unrolls, so each level
  // reduces to a fixed wiring pattern plus a 2:1 (or 4:1) mux.
  always_comb begin
    d = operand;
    for (int unsigned j = 0; j < NUM_LVL; j++) begin
      int unsigned lvl;
      int unsigned amt;
      lvl = FIRST_LVL + j;
      amt = 1 << lvl;
      if (lvl < SW) begin
        if (((shamt >> lvl) & SW'(1)) != '0) begin
          case (op)
            SHIFT_SLL: d = d << amt;
            SHIFT_SRL: d = d >> amt;
            SHIFT_SRA: d = (d >> amt) |
                           ({WIDTH{sign}} & ~({WIDTH{1'b1}} >> amt));
`ifdef SHIFT_ROTATE_EN
            SHIFT_ROL: d = (d << amt) | (d >> (WIDTH - amt));
            SHIFT_ROR: d = (d >> amt) | (d << (WIDTH - amt));
`else
            SHIFT_ROL, SHIFT_ROR: d = d;
`endif
            default:   d = d;
          endcase
        end
      end
    end
  end

  assign result = d;

  // Pass-through slices do not look at the control inputs at all.
  logic unused_ctrl;
  assign unused_ctrl = ^{shamt, op, sign};

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined barrel shifter with valid/ready on both sides.
// $clog2(WIDTH) mux levels are spread over STAGES register stages; each
// stage register holds data, shift amount, op, tag, illegal, sign and valid.
// Latency is STAGES cycles, throughput one beat per cycle.
// Optional feature macro: SHIFT_ROTATE_EN (ROL/ROR legal when defined,
// otherwise they are reported as illegal with a zero result).
// Ports:
//   i_clk, i_rst_n      : clock (rising edge), synchronous active-low reset
//   i_valid / o_ready   : input handshake
//   i_data, i_shamt     : operand and shift amount
//   i_op                : op code (see shift_op_e), i_tag : sideband tag
//   o_valid / i_ready   : output handshake
//   o_data, o_tag       : result and its tag
//   o_illegal           : op code unsupported, o_data is 0
module shift_unit_pipe
  import shift_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2,
  parameter int unsigned TAG_W  = 5
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [WIDTH-1:0]         i_data,
  input  logic [$clog2(WIDTH)-1:0] i_shamt,
  input  logic [2:0]               i_op,
  input  logic [TAG_W-1:0]         i_tag,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [WIDTH-1:0]         o_data,
  output logic [TAG_W-1:0]         o_tag,
  output logic                     o_illegal
);

  localparam int unsigned SW            = shamt_w(WIDTH);
  localparam int unsigned LVL_PER_STAGE = lvl_per_stage(WIDTH, STAGES);

  if ((WIDTH < 8) || (WIDTH > 64) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("shift_unit_pipe: WIDTH must be a power of 2 in 8..64");
  end
  if ((STAGES < 1) || (STAGES > SW)) begin : g_bad_stages
    $error("shift_unit_pipe: STAGES must be in 1..$clog2(WIDTH)");
  end

  // Stage registers
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ill_q;
  logic [STAGES-1:0] sign_q;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [SW-1:0]     shamt_q [STAGES];
  shift_op_e         op_q    [STAGES];
  logic [TAG_W-1:0]  tag_q   [STAGES];

  // Values presented to each stage (port side for stage 0)
  logic [STAGES-1:0] in_valid;
  logic [STAGES-1:0] in_ill;
  logic [STAGES-1:0] in_sign;
  logic [WIDTH-1:0]  in_data  [STAGES];
  logic [SW-1:0]     in_shamt [STAGES];
  shift_op_e         in_op    [STAGES];
  logic [TAG_W-1:0]  in_tag   [STAGES];
  logic [WIDTH-1:0]  res      [STAGES];

  logic [STAGES:0]   ready;

  shift_op_e op_in;
  logic      illegal_in;

  assign op_in = shift_op_e'(i_op);

  always_comb begin
    illegal_in = 1'b1;
    case (op_in)
      SHIFT_SLL, SHIFT_SRL, SHIFT_SRA: illegal_in = 1'b0;
`ifdef SHIFT_ROTATE_EN
      SHIFT_ROL, SHIFT_ROR:            illegal_in = 1'b0;
`else
      SHIFT_ROL, SHIFT_ROR:            illegal_in = 1'b1;
`endif
      default:                         illegal_in = 1'b1;
    endcase
  end

  assign ready[STAGES] = i_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      // Illegal beats enter as zero so every level keeps them zero.
      assign in_valid[0] = i_valid;
      assign in_data[0]  = illegal_in ? '0 : i_data;
      assign in_shamt[0] = i_shamt;
      assign in_op[0]    = op_in;
      assign in_tag[0]   = i_tag;
      assign in_ill[0]   = illegal_in;
      assign in_sign[0]  = !illegal_in & i_data[WIDTH-1];
    end else begin : g_link
      assign in_valid[k] = valid_q[k-1];
      assign in_data[k]  = data_q[k-1];
      assign in_shamt[k] = shamt_q[k-1];
      assign in_op[k]    = op_q[k-1];
      assign in_tag[k]   = tag_q[k-1];
      assign in_ill[k]   = ill_q[k-1];
      assign in_sign[k]  = sign_q[k-1];
    end

    // Closed form of ready_k = !valid_k | ready_(k+1): a stage may load if
    // the sink is ready or any stage from here to the output holds a bubble.
    assign ready[k] = i_ready | ~(&valid_q[STAGES-1:k]);

    shift_stage #(
      .WIDTH     (WIDTH),
      .FIRST_LVL (k * LVL_PER_STAGE),
      .NUM_LVL   (LVL_PER_STAGE)
    ) u_stage (
      .operand (in_data[k]),
      .shamt   (in_shamt[k]),
      .op      (in_op[k]),
      .sign    (in_sign[k]),
      .result  (res[k])
    );
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      ill_q   <= '0;
      sign_q  <= '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        data_q[k]  <= '0;
        shamt_q[k] <= '0;
        op_q[k]    <= SHIFT_SLL;
        tag_q[k]   <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= in_valid[k];
          ill_q[k]   <= in_ill[k];
          sign_q[k]  <= in_sign[k];
          data_q[k]  <= res[k];
          shamt_q[k] <= in_shamt[k];
          op_q[k]    <= in_op[k];
          tag_q[k]   <= in_tag[k];
        end
      end
    end
  end

  assign o_ready   = ready[0];
  assign o_valid   = valid_q[STAGES-1];
  assign o_data    = data_q[STAGES-1];
  assign o_tag     = tag_q[STAGES-1];
  assign o_illegal = ill_q[STAGES-1];

  // Control fields of the last stage have no downstream consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_q[STAGES-1], op_q[STAGES-1], sign_q[STAGES-1]};

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Scoreboard bench for shift_unit_pipe. Accepted beats are turned into
// expected results by an arithmetic reference model and queued; a separate
// monitor pops and compares whenever the DUT hands out a result.
// Honours SHIFT_ROTATE_EN the same way as the design.
module tb_shift_unit_pipe;

  parameter int unsigned WIDTH  = 32;
  parameter int unsigned STAGES = 2;
  parameter int unsigned TAG_W  = 5;

  localparam int unsigned SW = $clog2(WIDTH);
`ifdef SHIFT_ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic             i_clk;
  logic             i_rst_n;
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_data;
  logic [SW-1:0]    i_shamt;
  logic [2:0]       i_op;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_data;
  logic [TAG_W-1:0] o_tag;
  logic             o_illegal;

  shift_unit_pipe #(.WIDTH(WIDTH), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_data    (i_data),
    .i_shamt   (i_shamt),
    .i_op      (i_op),
    .i_tag     (i_tag),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_data    (o_data),
    .o_tag     (o_tag),
    .o_illegal (o_illegal)
  );

  typedef struct {
    logic [WIDTH-1:0] data;
    logic [TAG_W-1:0] tag;
    logic             ill;
    int               acc_cyc;
    bit               exact;
  } exp_t;

  exp_t             sb[$];
  int               checks = 0;
  int               failures = 0;
  int               cyc = 0;
  bit               exact_phase = 1'b1;
  bit               rand_ready = 1'b0;
  logic [TAG_W-1:0] tag_ctr = '0;

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input bit ok, input string name, input string detail);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  // Reference model: the shift rules in plain arithmetic.
  function automatic exp_t model(input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                                 input logic [2:0] op, input logic [TAG_W-1:0] tag);
    exp_t e;
    int unsigned n;
    logic signed [WIDTH-1:0] sd;
    n = s;
    sd = d;
    e.tag = tag;
    e.ill = 1'b0;
    e.acc_cyc = 0;
    e.exact = 1'b0;
    case (op)
      3'd0:    e.data = d << n;
      3'd1:    e.data = d >> n;
      3'd2:    e.data = sd >>> n;
      3'd3:    e.data = (n == 0) ? d : ((d << n) | (d >> (WIDTH - n)));
      3'd4:    e.data = (n == 0) ? d : ((d >> n) | (d << (WIDTH - n)));
      default: begin e.data = '0; e.ill = 1'b1; end
    endcase
    if (!ROT && (op == 3'd3 || op == 3'd4)) begin
      e.data = '0;
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [WIDTH-1:0] rand_data();
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    return r[WIDTH-1:0];
  endfunction

  // Acceptance monitor: pushes the expected result of every accepted beat.
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && i_valid && o_ready) begin
      e = model(i_data, i_shamt, i_op, i_tag);
      e.acc_cyc = cyc;
      e.exact = exact_phase;
      sb.push_back(e);
    end
  end

  // Output monitor: compares every delivered result, latency and stall hold.
  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_data;
  logic [TAG_W-1:0] prev_tag;
  logic             prev_ill;

  always @(negedge i_clk) begin
    exp_t e;
    int lat;
    if (!i_rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check(o_valid && o_data == prev_data && o_tag == prev_tag && o_illegal == prev_ill,
              "stall_hold", $sformatf("valid=%0b data=%h tag=%0d ill=%0b, required valid=1 data=%h tag=%0d ill=%0b",
                                      o_valid, o_data, o_tag, o_illegal, prev_data, prev_tag, prev_ill));
      end
      if (o_valid && i_ready) begin
        check(sb.size() != 0, "unexpected_out",
              $sformatf("result data=%h tag=%0d delivered, required none pending", o_data, o_tag));
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check(o_data == e.data && o_tag == e.tag && o_illegal == e.ill, "result",
                $sformatf("data=%h tag=%0d ill=%0b, required data=%h tag=%0d ill=%0b",
                          o_data, o_tag, o_illegal, e.data, e.tag, e.ill));
          lat = cyc - e.acc_cyc;
          check(e.exact ? (lat == int'(STAGES)) : (lat >= int'(STAGES)), "latency",
                $sformatf("latency=%0d, required %s%0d", lat, e.exact ? "" : ">=", STAGES));
        end
      end
      prev_stall = o_valid && !i_ready;
      prev_data  = o_data;
      prev_tag   = o_tag;
      prev_ill   = o_illegal;
    end
  end

  // Random downstream readiness during the random phase.
  always @(posedge i_clk) begin
    #1;
    if (rand_ready) i_ready = ($urandom_range(0, 9) < 7);
  end

  // All drive tasks start and end 1 time unit after a rising edge.
  task automatic send(input logic [WIDTH-1:0] d, input logic [SW-1:0] s,
                      input logic [2:0] op, output int waited);
    bit acc;
    waited = 0;
    i_valid = 1'b1;
    i_data  = d;
    i_shamt = s;
    i_op    = op;
    i_tag   = tag_ctr;
    forever begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (acc) break;
      waited++;
      if (waited > 500) begin
        check(1'b0, "accept_timeout", $sformatf("beat tag=%0d not accepted in %0d cycles", tag_ctr, waited));
        break;
      end
    end
    tag_ctr++;
    i_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge i_clk);
      #1;
      n++;
    end
    check(sb.size() == 0, "drain", $sformatf("%0d results pending after %0d cycles, required 0", sb.size(), n));
  endtask

  task automatic load_beat();
    i_data  = rand_data();
    i_shamt = SW'($urandom());
    i_op    = 3'($urandom_range(0, 4));
    i_tag   = tag_ctr;
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    int waited;
    int acc_cnt;
    int exp_acc;
    bit acc;

    i_rst_n = 1'b0;
    i_valid = 1'b0;
    i_data  = '0;
    i_shamt = '0;
    i_op    = '0;
    i_tag   = '0;
    i_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    check(o_valid == 1'b0, "rst_valid", $sformatf("o_valid=%0b, required 0", o_valid));
    check(o_data == '0, "rst_data", $sformatf("o_data=%h, required 0", o_data));
    check(o_tag == '0, "rst_tag", $sformatf("o_tag=%0d, required 0", o_tag));
    check(o_illegal == 1'b0, "rst_illegal", $sformatf("o_illegal=%0b, required 0", o_illegal));
    check(o_ready == 1'b1, "rst_ready", $sformatf("o_ready=%0b, required 1", o_ready));
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    idle(1);

    // Directed beats, no backpressure, exact latency
    exact_phase = 1'b1;
    d = '0;
    d[WIDTH-1] = 1'b1;
    d[7:4] = 4'hF;
    send(d, SW'(4), 3'd2, waited);
    send(d, SW'(4), 3'd1, waited);
    send(WIDTH'(1), SW'(WIDTH - 1), 3'd0, waited);
    for (int op = 0; op < 5; op++) send(rand_data(), '0, 3'(op), waited);
    d = '0;
    d[WIDTH-1] = 1'b1;
    d[0] = 1'b1;
    send(d, SW'(1), 3'd3, waited);
    send(d, SW'(1), 3'd4, waited);
    for (int op = 5; op < 8; op++) send(rand_data(), SW'($urandom()), 3'(op), waited);
    drain();

    // Back-to-back stream of 8 beats, tags 0..7
    tag_ctr = '0;
    for (int b = 0; b < 8; b++) begin
      send(rand_data(), SW'($urandom()), 3'($urandom_range(0, 4)), waited);
      check(waited == 0, "b2b_ready", $sformatf("beat %0d waited %0d cycles, required 0", b, waited));
    end
    drain();

    // Backpressure: sink stalled for 5 cycles while the source keeps pushing
    exact_phase = 1'b0;
    i_ready = 1'b0;
    acc_cnt = 0;
    i_valid = 1'b1;
    load_beat();
    for (int c = 0; c < 5; c++) begin
      @(negedge i_clk);
      acc = o_ready;
      @(posedge i_clk);
      #1;
      if (acc) begin
        acc_cnt++;
        tag_ctr++;
        load_beat();
      end
    end
    exp_acc = (STAGES < 5) ? int'(STAGES) : 5;
    check(acc_cnt == exp_acc, "bp_accepts", $sformatf("accepted %0d beats, required %0d", acc_cnt, exp_acc));
    check(o_ready == (STAGES > 5), "bp_ready", $sformatf("o_ready=%0b, required %0b", o_ready, STAGES > 5));
    i_ready = 1'b1;
    send(i_data, i_shamt, i_op, waited);
    drain();

    // Random traffic with random backpressure and all op codes
    rand_ready = 1'b1;
    for (int b = 0; b < 300; b++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send(rand_data(), SW'($urandom()), 3'($urandom_range(0, 7)), waited);
    end
    rand_ready = 1'b0;
    @(posedge i_clk);
    #2;
    i_ready = 1'b1;
    drain();

    // Reset with beats in flight: they must vanish
    exact_phase = 1'b1;
    send(rand_data(), SW'($urandom()), 3'd0, waited);
    send(rand_data(), SW'($urandom()), 3'd1, waited);
    i_rst_n = 1'b0;
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    sb.delete();
    @(negedge i_clk);
    check(o_valid == 1'b0, "rst_flush", $sformatf("o_valid=%0b after reset, required 0", o_valid));
    idle(10);
    d = '0;
    d[WIDTH-1] = 1'b1;
    d[7:4] = 4'hF;
    send(d, SW'(4), 3'd2, waited);
    drain();

    check(sb.size() == 0, "final_empty", $sformatf("%0d results pending, required 0", sb.size()));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
